sdram_port_arb: RTL
===================

Name: sdram_port_arb

Overview:
Shares the single byte-wide SDRAM request port (rd_req/wr_req pulse, level ready, 8-bit q) among NUM_REQ requesters: SNI debug UART, cartridge/ROM loader, and the core-side mapper.
- Requester 0 (core) has fixed priority, bounded by an anti-starvation counter.
- Requesters 1..NUM_REQ-1 are served round-robin.
- Each requester keeps the same pulse/ready contract it would see on a private port, so SNI-style clients attach unchanged.

Parameters:
NUM_REQ, 3, number of requesters (2..8); index 0 is the priority requester
ADDR_W, 25, SDRAM byte address width
STARVE_MAX, 8, max consecutive grants to requester 0 while any other requester is pending

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_rd  in  NUM_REQ  per-requester single-cycle read request pulse
req_wr  in  NUM_REQ  per-requester single-cycle write request pulse
req_addr  in  NUM_REQ*ADDR_W  per-requester address, slice i = [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*8  per-requester write data
req_ready  out  NUM_REQ  per-requester ready level; low while that requester's op is pending
req_q  out  NUM_REQ*8  per-requester read data, held until that requester's next completion
req_err  out  NUM_REQ  sticky protocol-error flag per requester
mem_addr  out  ADDR_W  SDRAM address
mem_data  out  8  SDRAM write data
mem_rd_req  out  1  SDRAM read pulse
mem_wr_req  out  1  SDRAM write pulse
mem_q  in  8  SDRAM read data
mem_ready  in  1  SDRAM ready; low from the cycle after a pulse until the op completes
grant_id  out  3  index of the current or last granted requester
busy  out  1  high in GUARD/WAIT

Behaviour:
- Reset (async, while reset_n=0): pend=0, req_ready=all 1, req_q=0, req_err=0, mem_*_req=0, mem_addr=0, mem_data=0, grant_id=0, busy=0, starve=0, rr_ptr=1, state=IDLE.
- Reset mid-operation: the in-flight SDRAM op is abandoned; its completion is never forwarded.
- Capture:
  - req_rd[i] or req_wr[i] high at cycle t with pend[i]=0: latch addr, wdata and op (wr=1 if req_wr) into slot i; set pend[i]; req_ready[i]=0 from t+1.
  - req_rd and req_wr both high: treated as a write and sets req_err[i].
  - A request while pend[i]=1 is ignored and sets req_err[i].
- Winner selection (IDLE, registered):
  - Requester 0 wins if pending and (starve<STARVE_MAX or no other requester is pending).
  - Otherwise the first pending index in round-robin order starting at rr_ptr over 1..NUM_REQ-1 wins.
- Starve counter:
  - Grant to 0 while others are pending: starve+1, saturating.
  - Grant to others: starve=0 and rr_ptr=winner+1, wrapping NUM_REQ-1 -> 1.
  - Grant to 0 with no others pending: starve=0.
- FSM, IDLE -> GUARD -> WAIT -> IDLE:
  - IDLE: if any pend, register mem_addr/mem_data from the winner slot, pulse mem_rd_req or mem_wr_req for exactly 1 cycle, set grant_id, go to GUARD.
  - GUARD: 1 cycle; mem_ready is ignored while downstream drops ready. Go to WAIT.
  - WAIT: on mem_ready=1, for reads copy mem_q into req_q[grant_id]; clear pend[grant_id]; req_ready[grant_id]=1 next cycle; go to IDLE.
  - The next grant may issue on the cycle after the return to IDLE.
- Latency: request at t -> mem pulse at t+2. Completion sampled at c -> req_ready/req_q valid at c+1.
- Simultaneous events:
  - A new request from the granted requester on its completion cycle is captured; pend stays set and ready stays low.
  - All requesters requesting on the same cycle are captured independently.
- Outputs are registered. mem_addr/mem_data are held stable from the pulse until the next grant.
- A write leaves req_q unchanged.

Decomposition:
- Package sdram_arb_pkg: state enum {IDLE, GUARD, WAIT}, op encoding (OP_RD=0, OP_WR=1), GRANT_W localparam.
- Sub-module rr_pick: combinational round-robin first-set search over a pending vector from a start pointer; returns index and valid.
- Slots, FSM and starve logic stay in the top module.

Test Plan:
- Single read: req_rd[1] with addr 0x0123456 at t -> mem_rd_req at t+2 with mem_addr 0x0123456; mem_ready returns with mem_q=0xA5 -> req_q[1]=0xA5 and req_ready[1]=1 one cycle later.
- Write: req_wr[2] with addr 0x1000000, wdata 0x3C -> mem_wr_req pulse, mem_data=0x3C; req_q[2] unchanged.
- Starvation bound: requester 0 re-requests on every completion while req 1 is pending -> exactly 8 grants to 0, then 1 is granted, then starve resets.
- Round-robin: reqs 1 and 2 pulse together, then repeat on every completion -> grant order 1,2,1,2.
- Protocol errors: second req_rd[1] while pending -> ignored, req_err[1]=1, one mem pulse only. Rd+wr same cycle -> write issued, req_err set.
- Reset mid-WAIT: reset_n low while waiting -> all ready=1, no mem pulse; a later mem_ready does not update req_q.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, op encoding and the grant index width.
// No logic here; the latency and backpressure notes live in the modules that use these types.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GUARD,
      WAIT
   } state_t;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   localparam int GRANT_W = 3;

endpackage

// File: rtl/sdram_port_arb_rr_pick.sv
// Round-robin first-set search over requesters 1..N-1 from start, wrapping N-1 -> 1; index 0 is never picked.
// Purely combinational (0 cycles), no backpressure; vld is low when nothing in 1..N-1 is pending.
module rr_pick
   import sdram_arb_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0]         pend,
   input  logic [GRANT_W-1:0]   start,
   output logic [GRANT_W-1:0]   idx,
   output logic                 vld
);

   localparam int CW = GRANT_W + 1;

   logic [(2**GRANT_W)-1:0] pend_pad;
   logic [CW-1:0]           cand;

   assign pend_pad = (2**GRANT_W)'(pend);

   always_comb begin
      idx  = '0;
      vld  = 1'b0;
      cand = '0;
      for (int k = 0; k < N - 1; k++) begin
         cand = CW'(start) + CW'(k);
         if (cand > CW'(N - 1)) begin
            cand = cand - CW'(N - 1);
         end
         if (!vld && pend_pad[cand[GRANT_W-1:0]]) begin
            vld = 1'b1;
            idx = cand[GRANT_W-1:0];
         end
      end
   end

endmodule

// File: rtl/sdram_port_arb.sv
// Shares one byte-wide SDRAM pulse/ready port among NUM_REQ clients; request at t -> mem pulse at t+2, completion at c -> ready/q at c+1.
// Each client sees a private-port contract: req_ready drops while its op is pending, and extra pulses are dropped and flagged in req_err.
module sdram_port_arb
   import sdram_arb_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int ADDR_W     = 25,
   parameter int STARVE_MAX = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_rd,
   input  logic [NUM_REQ-1:0]        req_wr,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*8-1:0]      req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ*8-1:0]      req_q,
   output logic [NUM_REQ-1:0]        req_err,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [7:0]                mem_data,
   output logic                      mem_rd_req,
   output logic                      mem_wr_req,
   input  logic [7:0]                mem_q,
   input  logic                      mem_ready,
   output logic [GRANT_W-1:0]        grant_id,
   output logic                      busy
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   state_t               state, state_nx;
   logic [NUM_REQ-1:0]   pend;
   logic [ADDR_W-1:0]    slot_addr [NUM_REQ];
   logic [7:0]           slot_wdata [NUM_REQ];
   logic [NUM_REQ-1:0]   slot_op;
   logic [SW-1:0]        starve;
   logic [GRANT_W-1:0]   rr_ptr, rr_idx, win;
   logic                 rr_vld, others_pend, issue, done;
   logic [ADDR_W-1:0]    win_addr;
   logic [7:0]           win_data;
   logic                 win_op;
   logic [NUM_REQ-1:0]   done_vec, accept, err_hit;

   rr_pick #(.N(NUM_REQ)) u_rr_pick (
      .pend  (pend),
      .start (rr_ptr),
      .idx   (rr_idx),
      .vld   (rr_vld)
   );

   assign others_pend = |pend[NUM_REQ-1:1];
   assign req_ready   = ~pend;
   assign busy        = (state != IDLE);

   // Requester 0 yields only once it has starved the others for STARVE_MAX grants.
   always_comb begin
      win = '0;
      if (!(pend[0] && ((starve < SW'(STARVE_MAX)) || !others_pend)) && rr_vld) begin
         win = rr_idx;
      end
      win_addr = '0;
      win_data = '0;
      win_op   = OP_RD;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win == GRANT_W'(i)) begin
            win_addr = slot_addr[i];
            win_data = slot_wdata[i];
            win_op   = slot_op[i];
         end
      end
   end

   always_comb begin
      state_nx = state;
      issue    = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (|pend) begin
               issue    = 1'b1;
               state_nx = GUARD;
            end
         end
         GUARD: state_nx = WAIT;
         WAIT: begin
            if (mem_ready) begin
               done     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // The completing requester may re-request in its completion cycle; that capture is legal.
   always_comb begin
      done_vec = '0;
      accept   = '0;
      err_hit  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         done_vec[i] = done && (grant_id == GRANT_W'(i));
         accept[i]   = (req_rd[i] | req_wr[i]) && (!pend[i] || done_vec[i]);
         err_hit[i]  = (req_rd[i] & req_wr[i])
                     | ((req_rd[i] | req_wr[i]) & pend[i] & ~done_vec[i]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend    <= '0;
         req_err <= '0;
         req_q   <= '0;
         slot_op <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            slot_addr[i]  <= '0;
            slot_wdata[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (done_vec[i]) begin
               pend[i] <= 1'b0;
               if (slot_op[i] == OP_RD) begin
                  req_q[i*8 +: 8] <= mem_q;
               end
            end
            if (accept[i]) begin
               pend[i]       <= 1'b1;
               slot_addr[i]  <= req_addr[i*ADDR_W +: ADDR_W];
               slot_wdata[i] <= req_wdata[i*8 +: 8];
               slot_op[i]    <= req_wr[i];
            end
            if (err_hit[i]) begin
               req_err[i] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_rd_req <= 1'b0;
         mem_wr_req <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= '0;
         grant_id   <= '0;
         starve     <= '0;
         rr_ptr     <= GRANT_W'(1);
      end else begin
         mem_rd_req <= issue && (win_op == OP_RD);
         mem_wr_req <= issue && (win_op == OP_WR);
         if (issue) begin
            mem_addr <= win_addr;
            mem_data <= win_data;
            grant_id <= win;
            if (win == '0) begin
               if (!others_pend) begin
                  starve <= '0;
               end else if (starve != SW'(STARVE_MAX)) begin
                  starve <= starve + SW'(1);
               end
            end else begin
               starve <= '0;
               rr_ptr  <= (win == GRANT_W'(NUM_REQ - 1)) ? GRANT_W'(1) : win + GRANT_W'(1);
            end
         end
      end
   end

endmodule
